pic24_fetch_unit: RTL and testbench

//  Instruction fetch stage directly downstream of the program counter.
//  - Takes the current PC and issues word reads to program memory over a req/ack bus.
//  - Requests a PC increment for every accepted instruction.
//  - Buffers fetched {address, instruction} pairs in a small FIFO for the decoder
//    (valid/ready handshake).
//  - Flushes on branch/PC load.

---
 rtl/pic24_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_pic24_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pic24_fetch_unit.sv
// Instruction fetch: PC-aligned program-memory reads queued as {addr,instr} pairs for decode.
// Latency: request one edge after IDLE with a free slot; the word is at the FIFO head the cycle after ack.
// Backpressure: no request while the FIFO is full, flush_i is high or (with FETCH_TIMEOUT_EN) fetch_err_o is set.
module pic24_fetch_unit #(
    parameter int AW             = 24,
    parameter int IW             = 24,
    parameter int DEPTH          = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [AW-1:0] pc_addr_i,
    output logic          pc_inc_o,
    output logic          pm_req_o,
    output logic [AW-1:0] pm_addr_o,
    input  logic          pm_ack_i,
    input  logic [IW-1:0] pm_rdata_i,
    input  logic          flush_i,
    output logic          instr_valid_o,
    output logic [IW-1:0] instr_o,
    output logic [AW-1:0] instr_addr_o,
    input  logic          instr_ready_i,
    output logic          fetch_err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DISCARD  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          issue, push, pop, tmo_hit;
    logic [AW-1:0] pc_aligned;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0] addr_mem [DEPTH];
    logic [IW-1:0] data_mem [DEPTH];

    // Program memory is word addressed in steps of 2, so bit 0 of the PC never reaches the bus.
    assign pc_aligned = pc_addr_i & ~AW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (issue) state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (pm_ack_i || tmo_hit) state_nxt = IDLE;
                else if (flush_i)        state_nxt = DISCARD;
            end
            DISCARD:  if (pm_ack_i || tmo_hit) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue    = 1'b0;
        push     = 1'b0;
        pc_inc_o = 1'b0;
        case (state)
            IDLE:     issue = (count < CW'(DEPTH)) && !flush_i && !fetch_err_o;
            WAIT_ACK: if (pm_ack_i && !flush_i) begin
                push     = 1'b1;
                pc_inc_o = 1'b1;
            end
            default:  ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pm_req_o  <= 1'b0;
            pm_addr_o <= '0;
        end else if (issue) begin
            pm_req_o  <= 1'b1;
            pm_addr_o <= pc_aligned;
        end else if (state != IDLE && (pm_ack_i || tmo_hit)) begin
            pm_req_o  <= 1'b0;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    assign tmo_hit     = (state != IDLE) && !pm_ack_i && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign fetch_err_o = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE || pm_ack_i || tmo_hit) tmo_cnt <= '0;
            else                                      tmo_cnt <= tmo_cnt + TW'(1);
            if (flush_i)      err_q <= 1'b0;
            else if (tmo_hit) err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign fetch_err_o = 1'b0;
`endif

    assign instr_valid_o = (count != '0);
    assign instr_o       = data_mem[rd_ptr];
    assign instr_addr_o  = addr_mem[rd_ptr];
    assign pop           = instr_valid_o && instr_ready_i && !flush_i;

    // Issue only with a free slot, so a push never lands on a full FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (flush_i) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                addr_mem[wr_ptr] <= pm_addr_o;
                data_mem[wr_ptr] <= pm_rdata_i;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_pic24_fetch_unit.sv
// Directed bench for pic24_fetch_unit (DEPTH=2, TIMEOUT_CYCLES=8); acts as PC and program memory.
module tb_pic24_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [23:0] pc_addr_i = '0;
    logic        pc_inc_o;
    logic        pm_req_o;
    logic [23:0] pm_addr_o;
    logic        pm_ack_i = 1'b0;
    logic [23:0] pm_rdata_i = '0;
    logic        flush_i = 1'b0;
    logic        instr_valid_o;
    logic [23:0] instr_o;
    logic [23:0] instr_addr_o;
    logic        instr_ready_i = 1'b0;
    logic        fetch_err_o;

    int errors = 0;
    int checks = 0;
    int inc_cnt = 0;

    pic24_fetch_unit #(.AW(24), .IW(24), .DEPTH(2), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .pc_addr_i(pc_addr_i), .pc_inc_o(pc_inc_o),
        .pm_req_o(pm_req_o), .pm_addr_o(pm_addr_o), .pm_ack_i(pm_ack_i),
        .pm_rdata_i(pm_rdata_i), .flush_i(flush_i), .instr_valid_o(instr_valid_o),
        .instr_o(instr_o), .instr_addr_o(instr_addr_o), .instr_ready_i(instr_ready_i),
        .fetch_err_o(fetch_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs settle, pc_inc_o is sampled, then the bench's PC advances like the real one.
    task automatic tick();
        logic inc;
        #1;
        inc = pc_inc_o;
        @(posedge clk_i);
        #2;
        if (inc) begin
            pc_addr_i = pc_addr_i + 24'd2;
            inc_cnt++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req"},   {31'd0, pm_req_o},      32'd0);
        chk({tag, ".addr"},  {8'd0, pm_addr_o},      32'd0);
        chk({tag, ".inc"},   {31'd0, pc_inc_o},      32'd0);
        chk({tag, ".vld"},   {31'd0, instr_valid_o}, 32'd0);
        chk({tag, ".instr"}, {8'd0, instr_o},        32'd0);
        chk({tag, ".iaddr"}, {8'd0, instr_addr_o},   32'd0);
        chk({tag, ".err"},   {31'd0, fetch_err_o},   32'd0);
    endtask

    initial begin
        // Test 1: reset state, first request, reset while waiting for ack
        #12;
        chk_all_zero("rst");
        rst_ni = 1'b1;
        tick();
        chk("t1.req", {31'd0, pm_req_o}, 32'd1);
        chk("t1.addr", {8'd0, pm_addr_o}, 32'h000000);
        rst_ni = 1'b0;
        #1;
        chk_all_zero("t1.rst_mid");

        // Test 2: sequential fetch, ack one cycle after request, decoder always ready
        pc_addr_i = 24'h000100;
        instr_ready_i = 1'b1;
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2.req", {31'd0, pm_req_o}, 32'd1);
            chk("t2.addr", {8'd0, pm_addr_o}, 32'h100 + 32'(2 * i));
            pm_ack_i = 1'b1;
            pm_rdata_i = 24'hA00000 + 24'(i);
            #1;
            chk("t2.inc_ack", {31'd0, pc_inc_o}, 32'd1);
            tick();
            pm_ack_i = 1'b0;
            #1;
            chk("t2.inc_gap", {31'd0, pc_inc_o}, 32'd0);
            chk("t2.req_off", {31'd0, pm_req_o}, 32'd0);
            chk("t2.vld", {31'd0, instr_valid_o}, 32'd1);
            chk("t2.iaddr", {8'd0, instr_addr_o}, 32'h100 + 32'(2 * i));
            chk("t2.instr", {8'd0, instr_o}, 32'hA00000 + 32'(i));
        end
        chk("t2.inc_cnt", inc_cnt, 32'd3);

        // Test 3: decoder stalled, FIFO fills to DEPTH=2 and requests stop
        tick();
        chk("t3.req0", {31'd0, pm_req_o}, 32'd1);
        chk("t3.addr0", {8'd0, pm_addr_o}, 32'h106);
        chk("t3.vld0", {31'd0, instr_valid_o}, 32'd0);
        instr_ready_i = 1'b0;
        pm_ack_i = 1'b1;
        tick();
        pm_ack_i = 1'b0;
        tick();
        chk("t3.addr1", {8'd0, pm_addr_o}, 32'h108);
        pm_ack_i = 1'b1;
        tick();
        pm_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t3.full_req", {31'd0, pm_req_o}, 32'd0);
        chk("t3.full_head", {8'd0, instr_addr_o}, 32'h106);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        chk("t3.pop_head", {8'd0, instr_addr_o}, 32'h108);
        tick();
        chk("t3.req_again", {31'd0, pm_req_o}, 32'd1);
        chk("t3.addr_again", {8'd0, pm_addr_o}, 32'h10A);
        pm_ack_i = 1'b1;
        tick();
        pm_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("t3.one_req", {31'd0, pm_req_o}, 32'd0);
        chk("t3.inc_cnt", inc_cnt, 32'd6);

        // Test 4: flush while waiting for ack; late ack is dropped
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t4.flush_vld", {31'd0, instr_valid_o}, 32'd0);
        pc_addr_i = 24'h0001F0;
        tick();
        chk("t4.req", {31'd0, pm_req_o}, 32'd1);
        chk("t4.addr", {8'd0, pm_addr_o}, 32'h1F0);
        flush_i = 1'b1;
        pc_addr_i = 24'h000200;
        tick();
        flush_i = 1'b0;
        chk("t4.req_held", {31'd0, pm_req_o}, 32'd1);
        tick();
        tick();
        pm_ack_i = 1'b1;
        pm_rdata_i = 24'h00DEAD;
        #1;
        chk("t4.no_inc", {31'd0, pc_inc_o}, 32'd0);
        tick();
        pm_ack_i = 1'b0;
        chk("t4.vld", {31'd0, instr_valid_o}, 32'd0);
        chk("t4.req_drop", {31'd0, pm_req_o}, 32'd0);
        tick();
        chk("t4.new_req", {31'd0, pm_req_o}, 32'd1);
        chk("t4.new_addr", {8'd0, pm_addr_o}, 32'h200);
        chk("t4.inc_cnt", inc_cnt, 32'd6);

        // Test 5: flush coincides with ack while one entry is buffered and ready=1
        pm_ack_i = 1'b1;
        pm_rdata_i = 24'h123456;
        tick();
        pm_ack_i = 1'b0;
        chk("t5.vld1", {31'd0, instr_valid_o}, 32'd1);
        chk("t5.head", {8'd0, instr_addr_o}, 32'h200);
        tick();
        chk("t5.addr", {8'd0, pm_addr_o}, 32'h202);
        instr_ready_i = 1'b1;
        flush_i = 1'b1;
        pm_ack_i = 1'b1;
        pm_rdata_i = 24'h00BEEF;
        #1;
        chk("t5.no_inc", {31'd0, pc_inc_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        pm_ack_i = 1'b0;
        instr_ready_i = 1'b0;
        chk("t5.empty", {31'd0, instr_valid_o}, 32'd0);
        chk("t5.req_off", {31'd0, pm_req_o}, 32'd0);
        tick();
        chk("t5.same_pc", {8'd0, pm_addr_o}, 32'h202);

`ifdef FETCH_TIMEOUT_EN
        // Test 6: no ack, error after 8 waiting cycles, cleared by flush
        for (int i = 0; i < 7; i++) tick();
        chk("t6.err_pre", {31'd0, fetch_err_o}, 32'd0);
        chk("t6.req_pre", {31'd0, pm_req_o}, 32'd1);
        tick();
        chk("t6.err", {31'd0, fetch_err_o}, 32'd1);
        chk("t6.req_off", {31'd0, pm_req_o}, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("t6.blocked", {31'd0, pm_req_o}, 32'd0);
        chk("t6.sticky", {31'd0, fetch_err_o}, 32'd1);
        flush_i = 1'b1;
        pc_addr_i = 24'h000300;
        tick();
        flush_i = 1'b0;
        chk("t6.err_clr", {31'd0, fetch_err_o}, 32'd0);
        tick();
        chk("t6.resume", {31'd0, pm_req_o}, 32'd1);
        chk("t6.resume_addr", {8'd0, pm_addr_o}, 32'h300);
`else
        // Without the timeout the request is held indefinitely and no error is raised
        for (int i = 0; i < 20; i++) tick();
        chk("t6.req_held", {31'd0, pm_req_o}, 32'd1);
        chk("t6.no_err", {31'd0, fetch_err_o}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
